// File: rtl/pipe_pkg.sv
// Shared definitions for the commit-point trap unit: CSR map, cause codes,
// error encodings, SYSTEM instruction encodings and the trap sequencer states.
package pipe_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam logic [6:0]  OPC_SYSTEM   = 7'h73;
    localparam logic [31:0] INSN_ECALL   = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET    = 32'h3020_0073;

    localparam logic [3:0]  ERR_NONE      = 4'd0;
    localparam logic [3:0]  ERR_ILLEGAL   = 4'd1;
    localparam logic [3:0]  ERR_FETCH_MIS = 4'd2;
    localparam logic [3:0]  ERR_LOAD_MIS  = 4'd3;
    localparam logic [3:0]  ERR_STORE_MIS = 4'd4;

    localparam logic [31:0] CAUSE_FETCH_MIS  = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MIS   = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MIS  = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_MTI        = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI        = 32'h8000_000B;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        TRAP_IDLE     = 2'd0,
        TRAP_FLUSH    = 2'd1,
        TRAP_REDIRECT = 2'd2
    } trap_state_e;

    // Unlisted error codes are reported as illegal instruction.
    function automatic logic [31:0] error_cause(input logic [3:0] err);
        case (err)
            ERR_FETCH_MIS: return CAUSE_FETCH_MIS;
            ERR_LOAD_MIS:  return CAUSE_LOAD_MIS;
            ERR_STORE_MIS: return CAUSE_STORE_MIS;
            default:       return CAUSE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/csr_regs.sv
// Machine-mode CSR storage: read mux, RW/RS/RC write path, trap/MRET state
// updates and the free-running 64-bit cycle counter.
module csr_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_src,
    input  logic        csr_we,
    input  logic        trap_take,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_cause,
    input  logic        mret_take,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] read_data,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        mstatus_mie,
    output logic [1:0]  irq_active
);

    logic        mie_bit_reg;
    logic        mpie_bit_reg;
    logic        meie_reg;
    logic        mtie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [63:0] mcycle_reg;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic [31:0] write_val;

    assign mstatus_val = {24'd0, mpie_bit_reg, 3'd0, mie_bit_reg, 3'd0};
    assign mie_val     = {20'd0, meie_reg, 3'd0, mtie_reg, 7'd0};
    assign mip_val     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};

    always_comb begin
        read_data = 32'd0;
        case (csr_addr)
            CSR_MSTATUS:  read_data = mstatus_val;
            CSR_MIE:      read_data = mie_val;
            CSR_MTVEC:    read_data = mtvec_reg;
            CSR_MSCRATCH: read_data = mscratch_reg;
            CSR_MEPC:     read_data = mepc_reg;
            CSR_MCAUSE:   read_data = mcause_reg;
            CSR_MIP:      read_data = mip_val;
            CSR_MCYCLE:   read_data = mcycle_reg[31:0];
            CSR_MCYCLEH:  read_data = mcycle_reg[63:32];
            default:      read_data = 32'd0;
        endcase
    end

    always_comb begin
        write_val = read_data;
        case (csr_op)
            CSR_OP_RW: write_val = csr_src;
            CSR_OP_RS: write_val = read_data | csr_src;
            CSR_OP_RC: write_val = read_data & ~csr_src;
            default:   write_val = read_data;
        endcase
    end

    // Trap entry, MRET and CSR writes are mutually exclusive by construction in the top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mie_bit_reg  <= 1'b0;
            mpie_bit_reg <= 1'b0;
            meie_reg     <= 1'b0;
            mtie_reg     <= 1'b0;
            mtvec_reg    <= {RESET_MTVEC[31:2], 2'b00};
            mscratch_reg <= 32'd0;
            mepc_reg     <= 32'd0;
            mcause_reg   <= 32'd0;
        end else if (trap_take) begin
            mepc_reg     <= {trap_epc[31:2], 2'b00};
            mcause_reg   <= trap_cause;
            mpie_bit_reg <= mie_bit_reg;
            mie_bit_reg  <= 1'b0;
        end else if (mret_take) begin
            mie_bit_reg  <= mpie_bit_reg;
            mpie_bit_reg <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_bit_reg  <= write_val[3];
                    mpie_bit_reg <= write_val[7];
                end
                CSR_MIE: begin
                    mtie_reg <= write_val[7];
                    meie_reg <= write_val[11];
                end
                CSR_MTVEC:    mtvec_reg    <= {write_val[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_reg <= write_val;
                CSR_MEPC:     mepc_reg     <= {write_val[31:2], 2'b00};
                CSR_MCAUSE:   mcause_reg   <= write_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcycle_reg <= 64'd0;
        end else begin
            mcycle_reg <= mcycle_reg + 64'd1;
        end
    end

    assign mtvec       = mtvec_reg;
    assign mepc        = mepc_reg;
    assign mstatus_mie = mie_bit_reg;
    assign irq_active  = {meie_reg & ext_irq, mtie_reg & timer_irq};

endmodule

// File: rtl/trap_ctrl.sv
// Commit-point trap controller: decodes WB events by priority and runs the
// two-cycle flush-then-redirect sequence towards the pipeline control unit.
module trap_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_1000,
    parameter int          XLEN        = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_is,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [3:0]      error,
    input  logic [XLEN-1:0] csr_rs1,
    input  logic            ext_irq,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush_all,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    trap_state_e state_reg;
    trap_state_e state_next;
    logic [31:0] target_reg;

    logic        live;
    logic        is_csr;
    logic        csr_write_req;
    logic        take_err;
    logic        take_sys;
    logic        take_mret;
    logic        take_irq;
    logic        trap_take;
    logic        csr_we;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] read_data;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mstatus_mie;
    logic [1:0]  irq_active;

    // Only a real instruction in WB while idle can raise an event.
    assign live          = (state_reg == TRAP_IDLE) && wb_valid;
    assign is_csr        = (wb_is[6:0] == OPC_SYSTEM) && (wb_is[14:12] != 3'd0);
    assign csr_write_req = is_csr && ((wb_is[13:12] == CSR_OP_RW) ||
                                      ((wb_is[13:12] != CSR_OP_NONE) && (csr_rs1 != 32'd0)));

    assign take_err  = live && (error != ERR_NONE);
    assign take_sys  = live && !take_err && ((wb_is == INSN_ECALL) || (wb_is == INSN_EBREAK));
    assign take_mret = live && !take_err && (wb_is == INSN_MRET);
    assign take_irq  = live && !take_err && !take_sys && !take_mret &&
                       mstatus_mie && (irq_active != 2'b00) && !csr_write_req;
    assign trap_take = take_err || take_sys || take_irq;
    assign csr_we    = live && csr_write_req && !take_err;
    assign trap_epc  = take_irq ? (wb_pc + 32'd4) : wb_pc;

    always_comb begin
        trap_cause = CAUSE_ILLEGAL;
        if (take_err) begin
            trap_cause = error_cause(error);
        end else if (take_sys) begin
            trap_cause = (wb_is == INSN_ECALL) ? CAUSE_ECALL_M : CAUSE_BREAKPOINT;
        end else if (irq_active[1]) begin
            trap_cause = CAUSE_MEI;
        end else begin
            trap_cause = CAUSE_MTI;
        end
    end

    csr_regs #(
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr_regs (
        .clk         (clk),
        .rstn        (rstn),
        .csr_addr    (wb_is[31:20]),
        .csr_op      (wb_is[13:12]),
        .csr_src     (csr_rs1),
        .csr_we      (csr_we),
        .trap_take   (trap_take),
        .trap_epc    (trap_epc),
        .trap_cause  (trap_cause),
        .mret_take   (take_mret),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .read_data   (read_data),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .mstatus_mie (mstatus_mie),
        .irq_active  (irq_active)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= TRAP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The target is latched at detect time, before MRET or trap entry touch mepc.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            target_reg <= 32'd0;
        end else if (trap_take || take_mret) begin
            target_reg <= take_mret ? mepc : mtvec;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TRAP_IDLE:     if (trap_take || take_mret) state_next = TRAP_FLUSH;
            TRAP_FLUSH:    state_next = TRAP_REDIRECT;
            TRAP_REDIRECT: state_next = TRAP_IDLE;
            default:       state_next = TRAP_IDLE;
        endcase
    end

    always_comb begin
        flush_all   = (state_reg != TRAP_IDLE);
        busy        = (state_reg != TRAP_IDLE);
        redirect_en = (state_reg == TRAP_REDIRECT);
        redirect_pc = (state_reg == TRAP_REDIRECT) ? target_reg : 32'd0;
        csr_rdata   = (live && is_csr) ? read_data : 32'd0;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, exceptions, ECALL, interrupts, MRET
// return, priority and CSR-write interlock, with hand-computed expectations.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_valid;
    logic [31:0] wb_is;
    logic [31:0] wb_pc;
    logic [3:0]  error;
    logic [31:0] csr_rs1;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        flush_all;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] MRET = 32'h3020_0073;

    always #5 clk = ~clk;

    trap_ctrl #(.RESET_MTVEC(32'h0000_1000), .XLEN(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb_valid    (wb_valid),
        .wb_is       (wb_is),
        .wb_pc       (wb_pc),
        .error       (error),
        .csr_rs1     (csr_rs1),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .csr_rdata   (csr_rdata),
        .flush_all   (flush_all),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] is, input logic [31:0] pc,
                         input logic [3:0] e, input logic [31:0] rs1);
        wb_valid = v;
        wb_is    = is;
        wb_pc    = pc;
        error    = e;
        csr_rs1  = rs1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0000_0013, 32'd0, 4'd0, 32'd0);
    endtask

    function automatic logic [31:0] csr_insn(input logic [11:0] a, input logic [2:0] f3);
        return {a, 5'd1, f3, 5'd2, 7'h73};
    endfunction

    // Presents a read-only CSRRS (source 0) in WB for one cycle and captures csr_rdata.
    task automatic read_csr(input logic [11:0] a, output logic [31:0] v);
        drive(1'b1, csr_insn(a, 3'b010), 32'h0000_0F00, 4'd0, 32'd0);
        @(negedge clk);
        v = csr_rdata;
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        logic [31:0] v, a, b;
        @(negedge clk);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL rst_flush got %b want 0", flush_all); end
        checks++; if (redirect_en !== 1'b0) begin errors++; $display("FAIL rst_redir_en got %b want 0", redirect_en); end
        checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL rst_redir_pc got %h want 0", redirect_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        step();
        rstn = 1'b1;
        step();
        read_csr(12'h305, v);
        checks++; if (v !== 32'h0000_1000) begin errors++; $display("FAIL rst_mtvec got %h want 00001000", v); end
        read_csr(12'h300, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mstatus got %h want 0", v); end
        read_csr(12'h7C0, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL unknown_csr got %h want 0", v); end
        read_csr(12'hB00, a);
        read_csr(12'hB00, b);
        checks++; if (b - a !== 32'd1) begin errors++; $display("FAIL mcycle_inc got %0d want 1", b - a); end
        $display("test_reset done: mtvec/mstatus/unknown/mcycle checked");
    endtask

    task automatic test_error();
        logic [31:0] v;
        drive(1'b1, ADD, 32'h80, 4'd1, 32'd0);
        @(negedge clk);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL err_n_flush got %b want 0", flush_all); end
        step();
        drive_idle();
        @(negedge clk);
        checks++; if (flush_all !== 1'b1 || redirect_en !== 1'b0) begin errors++; $display("FAIL err_n1 got flush=%b red=%b want 1 0", flush_all, redirect_en); end
        step();
        @(negedge clk);
        checks++; if (flush_all !== 1'b1 || redirect_en !== 1'b1) begin errors++; $display("FAIL err_n2 got flush=%b red=%b want 1 1", flush_all, redirect_en); end
        checks++; if (redirect_pc !== 32'h1000) begin errors++; $display("FAIL err_target got %h want 00001000", redirect_pc); end
        step();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || redirect_en !== 1'b0) begin errors++; $display("FAIL err_n3 got busy=%b red=%b want 0 0", busy, redirect_en); end
        read_csr(12'h341, v);
        checks++; if (v !== 32'h80) begin errors++; $display("FAIL err_mepc got %h want 00000080", v); end
        read_csr(12'h342, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL err_mcause got %h want 2", v); end
        read_csr(12'h300, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL err_mstatus got %h want 0", v); end
        $display("test_error done: illegal at 0x80 -> vector 0x1000");
    endtask

    task automatic test_csr_ecall();
        logic [31:0] v;
        drive(1'b1, csr_insn(12'h305, 3'b001), 32'h40, 4'd0, 32'h2003);
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h1000) begin errors++; $display("FAIL csrrw_old got %h want 00001000", csr_rdata); end
        step();
        drive(1'b1, 32'h0000_0073, 32'h100, 4'd0, 32'd0);
        step();
        drive_idle();
        step();
        @(negedge clk);
        checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h2000) begin errors++; $display("FAIL ecall_redir got en=%b pc=%h want 1 00002000", redirect_en, redirect_pc); end
        step();
        read_csr(12'h305, v);
        checks++; if (v !== 32'h2000) begin errors++; $display("FAIL new_mtvec got %h want 00002000", v); end
        read_csr(12'h342, v);
        checks++; if (v !== 32'd11) begin errors++; $display("FAIL ecall_mcause got %h want 0000000b", v); end
        read_csr(12'h341, v);
        checks++; if (v !== 32'h100) begin errors++; $display("FAIL ecall_mepc got %h want 00000100", v); end
        $display("test_csr_ecall done: mtvec=0x2000, ecall at 0x100");
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        drive(1'b1, ADD, 32'h300, 4'd4, 32'd0);
        step();
        drive_idle();
        step();
        @(negedge clk);
        checks++; if (redirect_en !== 1'b1) begin errors++; $display("FAIL mid_redir got %b want 1", redirect_en); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (flush_all !== 1'b0 || redirect_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got flush=%b red=%b busy=%b want 0 0 0", flush_all, redirect_en, busy); end
        checks++; if (redirect_pc !== 32'd0 || csr_rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_data got pc=%h rd=%h want 0 0", redirect_pc, csr_rdata); end
        step();
        rstn = 1'b1;
        step();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got busy=%b want 0", busy); end
        step();
        read_csr(12'h305, v);
        checks++; if (v !== 32'h1000) begin errors++; $display("FAIL mid_mtvec got %h want 00001000", v); end
        read_csr(12'h342, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_mcause got %h want 0", v); end
        $display("test_reset_mid done: reset during redirect");
    endtask

    task automatic test_irq_mret();
        logic [31:0] v;
        drive(1'b1, csr_insn(12'h300, 3'b010), 32'h10, 4'd0, 32'h8);
        step();
        drive(1'b1, csr_insn(12'h304, 3'b001), 32'h14, 4'd0, 32'h880);
        step();
        read_csr(12'h300, v);
        checks++; if (v !== 32'h8) begin errors++; $display("FAIL irq_mie_set got %h want 00000008", v); end
        read_csr(12'h304, v);
        checks++; if (v !== 32'h880) begin errors++; $display("FAIL irq_mie_reg got %h want 00000880", v); end
        ext_irq = 1'b1;
        timer_irq = 1'b1;
        drive(1'b1, ADD, 32'h200, 4'd0, 32'd0);
        step();
        drive_idle();
        @(negedge clk);
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL irq_taken got flush=%b want 1", flush_all); end
        step();
        @(negedge clk);
        checks++; if (redirect_pc !== 32'h1000) begin errors++; $display("FAIL irq_target got %h want 00001000", redirect_pc); end
        step();
        read_csr(12'h342, v);
        checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got %h want 8000000b", v); end
        read_csr(12'h341, v);
        checks++; if (v !== 32'h204) begin errors++; $display("FAIL irq_mepc got %h want 00000204", v); end
        read_csr(12'h300, v);
        checks++; if (v !== 32'h80) begin errors++; $display("FAIL irq_mstatus got %h want 00000080", v); end
        ext_irq = 1'b0;
        timer_irq = 1'b0;
        drive(1'b1, MRET, 32'h1010, 4'd0, 32'd0);
        step();
        drive_idle();
        step();
        @(negedge clk);
        checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h204) begin errors++; $display("FAIL mret_redir got en=%b pc=%h want 1 00000204", redirect_en, redirect_pc); end
        step();
        read_csr(12'h300, v);
        checks++; if (v !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h want 00000088", v); end
        $display("test_irq_mret done: ext irq at 0x200, return to 0x204");
    endtask

    task automatic test_error_vs_irq();
        logic [31:0] v;
        ext_irq = 1'b1;
        drive(1'b1, ADD, 32'h400, 4'd3, 32'd0);
        step();
        drive_idle();
        step();
        step();
        read_csr(12'h342, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL prio_mcause got %h want 4", v); end
        read_csr(12'h341, v);
        checks++; if (v !== 32'h400) begin errors++; $display("FAIL prio_mepc got %h want 00000400", v); end
        drive(1'b1, MRET, 32'h1020, 4'd0, 32'd0);
        step();
        drive_idle();
        step();
        @(negedge clk);
        checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL prio_mret got %h want 00000400", redirect_pc); end
        step();
        drive(1'b1, ADD, 32'h400, 4'd0, 32'd0);
        @(negedge clk);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL prio_ret_idle got %b want 0", flush_all); end
        step();
        drive_idle();
        @(negedge clk);
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL prio_irq_after got %b want 1", flush_all); end
        step();
        step();
        ext_irq = 1'b0;
        read_csr(12'h342, v);
        checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL prio_irq_cause got %h want 8000000b", v); end
        read_csr(12'h341, v);
        checks++; if (v !== 32'h404) begin errors++; $display("FAIL prio_irq_mepc got %h want 00000404", v); end
        $display("test_error_vs_irq done: load misaligned beats irq, irq after mret");
    endtask

    task automatic test_csr_blocks_irq();
        logic [31:0] v;
        drive(1'b1, csr_insn(12'h300, 3'b010), 32'h20, 4'd0, 32'h8);
        step();
        timer_irq = 1'b1;
        drive(1'b1, csr_insn(12'h300, 3'b010), 32'h24, 4'd0, 32'h8);
        @(negedge clk);
        checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL blk_rdata got %h want 00000088", csr_rdata); end
        step();
        drive(1'b1, ADD, 32'h500, 4'd0, 32'd0);
        @(negedge clk);
        checks++; if (flush_all !== 1'b0) begin errors++; $display("FAIL blk_no_trap got %b want 0", flush_all); end
        step();
        drive_idle();
        @(negedge clk);
        checks++; if (flush_all !== 1'b1) begin errors++; $display("FAIL blk_trap_next got %b want 1", flush_all); end
        step();
        step();
        timer_irq = 1'b0;
        read_csr(12'h342, v);
        checks++; if (v !== 32'h8000_0007) begin errors++; $display("FAIL blk_mcause got %h want 80000007", v); end
        read_csr(12'h341, v);
        checks++; if (v !== 32'h504) begin errors++; $display("FAIL blk_mepc got %h want 00000504", v); end
        $display("test_csr_blocks_irq done: timer irq deferred past CSR write");
    endtask

    initial begin
        rstn = 1'b0;
        ext_irq = 1'b0;
        timer_irq = 1'b0;
        drive_idle();
        test_reset();
        test_error();
        test_csr_ecall();
        test_reset_mid();
        test_irq_mret();
        test_error_vs_irq();
        test_csr_blocks_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
